// File: rtl/pixie_dma_responder.sv
// rtl/pixie_dma_responder.sv - CDP1802-style DMA-out / interrupt cycle sequencer for the Pixie display path
//
// Purpose:
//   Stands in for the CPU side of the Pixie display protocol. It runs machine
//   cycles of CYCLE_TICKS clk_enable ticks each. The next cycle type is chosen
//   on the last tick of the current one:
//   - dmao wins and starts a DMA-out cycle.
//   - Otherwise int_pixie with ie set starts an interrupt cycle.
//   - Otherwise the sequencer alternates fetch and execute.
//   A DMA-out cycle reads the byte at R0 onto data and then increments R0.
//   An interrupt cycle clears ie and reloads R0 with FB_BASE.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   clk_enable in   tick qualifier; sequencer state only advances when 1
//   dmao       in   DMA-out request
//   int_pixie  in   interrupt request
//   ie_set     in   one-clk pulse that sets ie (return from interrupt)
//   mem_addr   out  RAM read address (R0 during DMA cycles, else 0)
//   mem_rd_en  out  RAM read strobe, one enabled clk at tick 0 of a DMA cycle
//   mem_data   in   RAM read data, valid one clk after mem_rd_en
//   sc         out  state code: 0 fetch, 1 execute, 2 DMA, 3 interrupt
//   data       out  DMA bus byte; holds its value outside DMA cycles
//   tpb        out  timing pulse on the enabled clk at tick CYCLE_TICKS-2
//   ie         out  interrupt enable flag
//   r0         out  DMA pointer

module pixie_dma_responder #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] FB_BASE     = 16'h0100,
    parameter int                CYCLE_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              dmao,
    input  logic              int_pixie,
    input  logic              ie_set,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_data,
    output logic [1:0]        sc,
    output logic [7:0]        data,
    output logic              tpb,
    output logic              ie,
    output logic [ADDR_W-1:0] r0
);

    localparam int            TW        = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CYCLE_TICKS - 1);
    localparam logic [TW-1:0] TPB_TICK  = TW'(CYCLE_TICKS - 2);

    localparam logic [1:0] SC_FETCH = 2'd0;
    localparam logic [1:0] SC_EXEC  = 2'd1;
    localparam logic [1:0] SC_DMA   = 2'd2;
    localparam logic [1:0] SC_INT   = 2'd3;

    logic [1:0]        sc_q,   sc_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [ADDR_W-1:0] r0_q,   r0_d;
    logic              ie_q,   ie_d;
    logic [7:0]        data_q, data_d;
    // Set on the clk after a RAM read; marks the clk on which mem_data is valid.
    logic              cap_q,  cap_d;

    logic              last_tick;
    logic              rd_fire;
    logic [1:0]        next_cycle;

    assign last_tick = (tick_q == LAST_TICK);
    assign rd_fire   = clk_enable && (sc_q == SC_DMA) && (tick_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sc_q   <= SC_FETCH;
            tick_q <= '0;
            r0_q   <= FB_BASE;
            ie_q   <= 1'b1;
            data_q <= 8'h00;
            cap_q  <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            tick_q <= tick_d;
            r0_q   <= r0_d;
            ie_q   <= ie_d;
            data_q <= data_d;
            cap_q  <= cap_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // Cycle-type decision, used only on the last tick.
        next_cycle = SC_FETCH;
        if (dmao) begin
            next_cycle = SC_DMA;
        end else if (int_pixie && ie_q) begin
            next_cycle = SC_INT;
        end else if (sc_q == SC_FETCH) begin
            next_cycle = SC_EXEC;
        end else begin
            next_cycle = SC_FETCH;
        end

        sc_d   = sc_q;
        tick_d = tick_q;
        r0_d   = r0_q;
        ie_d   = ie_q;
        data_d = data_q;
        cap_d  = rd_fire;

        // The RAM capture follows the read by exactly one clk.
        // It is deliberately not gated by clk_enable.
        if (cap_q) begin
            data_d = mem_data;
        end

        if (ie_set) begin
            ie_d = 1'b1;
        end

        if (clk_enable) begin
            if (last_tick) begin
                tick_d = '0;
                sc_d   = next_cycle;
                if (sc_q == SC_DMA) begin
                    r0_d = r0_q + ADDR_W'(1);
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end

            // The acknowledge clear comes after the ie_set above, so it wins a tie.
            if ((sc_q == SC_INT) && (tick_q == '0)) begin
                ie_d = 1'b0;
                r0_d = FB_BASE;
            end
        end
    end

    // Outputs.
    always_comb begin
        sc        = sc_q;
        r0        = r0_q;
        ie        = ie_q;
        mem_rd_en = rd_fire;
        mem_addr  = (sc_q == SC_DMA) ? r0_q : '0;
        tpb       = clk_enable && (tick_q == TPB_TICK);
        // Forward the RAM byte on its capture clk.
        // This makes the byte visible from tick 1 even when clk_enable is high every clk.
        data      = cap_q ? mem_data : data_q;
    end

endmodule

// File: tb/tb_pixie_dma_responder.sv
// tb/tb_pixie_dma_responder.sv - directed vector bench for pixie_dma_responder

module tb_pixie_dma_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic clk_enable;

    logic        dmao_a, int_a, ie_set_a;
    logic [15:0] mem_addr_a, r0_a;
    logic        mem_rd_en_a, tpb_a, ie_a;
    logic [7:0]  mem_data_a = 8'h00;
    logic [7:0]  data_a;
    logic [1:0]  sc_a;

    logic        dmao_b, int_b, ie_set_b;
    logic [15:0] mem_addr_b, r0_b;
    logic        mem_rd_en_b, tpb_b, ie_b;
    logic [7:0]  mem_data_b = 8'h00;
    logic [7:0]  data_b;
    logic [1:0]  sc_b;

    pixie_dma_responder #(.ADDR_W(16), .FB_BASE(16'h0100), .CYCLE_TICKS(8)) u_dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .dmao(dmao_a), .int_pixie(int_a), .ie_set(ie_set_a),
        .mem_addr(mem_addr_a), .mem_rd_en(mem_rd_en_a), .mem_data(mem_data_a),
        .sc(sc_a), .data(data_a), .tpb(tpb_a), .ie(ie_a), .r0(r0_a)
    );

    pixie_dma_responder #(.ADDR_W(16), .FB_BASE(16'hFFFF), .CYCLE_TICKS(8)) u_dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .dmao(dmao_b), .int_pixie(int_b), .ie_set(ie_set_b),
        .mem_addr(mem_addr_b), .mem_rd_en(mem_rd_en_b), .mem_data(mem_data_b),
        .sc(sc_b), .data(data_b), .tpb(tpb_b), .ie(ie_b), .r0(r0_b)
    );

    logic [7:0] ram_a [256];

    always @(posedge clk) begin
        if (mem_rd_en_a) mem_data_a <= ram_a[mem_addr_a[7:0]];
        if (mem_rd_en_b) mem_data_b <= mem_addr_b[7:0] ^ 8'hC3;
    end

    // One row per machine cycle.
    // Inputs are held for the whole cycle; the ie_set pulse goes at the named tick (-1 = none).
    // Expected r0/ie/data are the values at tick 4 of that cycle.
    typedef struct {
        logic        dmao;
        logic        intp;
        int          ies_t;
        logic        bdmao;
        logic        bint;
        int          bies_t;
        logic [1:0]  sc;
        logic [15:0] r0;
        logic        ie;
        logic [7:0]  data;
        logic [1:0]  bsc;
        logic [15:0] br0;
        logic        bie;
        logic [7:0]  bdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   tpb_cnt_a, tpb_at_a, tpb_cnt_b, tpb_at_b, rd_cnt_a, rd_cnt_b;
        v = vt[i];
        tpb_cnt_a = 0; tpb_at_a = -1; tpb_cnt_b = 0; tpb_at_b = -1;
        rd_cnt_a = 0; rd_cnt_b = 0;
        dmao_a = v.dmao;
        int_a  = v.intp;
        dmao_b = v.bdmao;
        int_b  = v.bint;
        n_vec++;
        for (int t = 0; t < 8; t++) begin
            ie_set_a = (t == v.ies_t);
            ie_set_b = (t == v.bies_t);
            if (t == 0) begin
                check($sformatf("v%0d sc_a", i), 32'(sc_a), 32'(v.sc));
                check($sformatf("v%0d sc_b", i), 32'(sc_b), 32'(v.bsc));
            end
            if (tpb_a) begin tpb_cnt_a++; tpb_at_a = t; end
            if (tpb_b) begin tpb_cnt_b++; tpb_at_b = t; end
            if (mem_rd_en_a) begin
                rd_cnt_a++;
                check($sformatf("v%0d mem_addr_a", i), 32'(mem_addr_a), 32'(v.r0));
            end
            if (mem_rd_en_b) begin
                rd_cnt_b++;
                check($sformatf("v%0d mem_addr_b", i), 32'(mem_addr_b), 32'(v.br0));
            end
            if (t == 1 && v.sc == 2'd2)
                check($sformatf("v%0d data_a@tick1", i), 32'(data_a), 32'(v.data));
            if (t == 1 && v.bsc == 2'd2)
                check($sformatf("v%0d data_b@tick1", i), 32'(data_b), 32'(v.bdata));
            if (t == 4) begin
                check($sformatf("v%0d r0_a", i), 32'(r0_a), 32'(v.r0));
                check($sformatf("v%0d ie_a", i), 32'(ie_a), 32'(v.ie));
                check($sformatf("v%0d data_a", i), 32'(data_a), 32'(v.data));
                check($sformatf("v%0d r0_b", i), 32'(r0_b), 32'(v.br0));
                check($sformatf("v%0d ie_b", i), 32'(ie_b), 32'(v.bie));
                check($sformatf("v%0d data_b", i), 32'(data_b), 32'(v.bdata));
            end
            @(negedge clk);
        end
        ie_set_a = 1'b0;
        ie_set_b = 1'b0;
        check($sformatf("v%0d tpb_a count", i), 32'(tpb_cnt_a), 32'd1);
        check($sformatf("v%0d tpb_a tick", i), 32'(tpb_at_a), 32'd6);
        check($sformatf("v%0d tpb_b count", i), 32'(tpb_cnt_b), 32'd1);
        check($sformatf("v%0d rd_a count", i), 32'(rd_cnt_a), (v.sc == 2'd2) ? 32'd1 : 32'd0);
        check($sformatf("v%0d rd_b count", i), 32'(rd_cnt_b), (v.bsc == 2'd2) ? 32'd1 : 32'd0);
        check($sformatf("v%0d tpb_b tick", i), 32'(tpb_at_b), 32'd6);
    endtask

    initial begin
        int tpb_seen;

        //          dmao  int   iesT bdmao bint  biesT sc    r0        ie    data   bsc   br0       bie   bdata
        vt[0]  = '{1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 2'd0, 16'h0100, 1'b1, 8'h00, 2'd0, 16'hFFFF, 1'b1, 8'h00};
        vt[1]  = '{1'b0, 1'b0, -1, 1'b0, 1'b1, -1, 2'd1, 16'h0100, 1'b1, 8'h00, 2'd1, 16'hFFFF, 1'b1, 8'h00};
        vt[2]  = '{1'b0, 1'b0, -1, 1'b1, 1'b0,  0, 2'd0, 16'h0100, 1'b1, 8'h00, 2'd3, 16'hFFFF, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd1, 16'h0100, 1'b1, 8'h00, 2'd2, 16'hFFFF, 1'b0, 8'h3C};
        vt[4]  = '{1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0100, 1'b1, 8'hA5, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[5]  = '{1'b1, 1'b1, -1, 1'b0, 1'b0, -1, 2'd0, 16'h0101, 1'b1, 8'hA5, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[6]  = '{1'b0, 1'b1, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0101, 1'b1, 8'h3C, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[7]  = '{1'b0, 1'b1, -1, 1'b0, 1'b0, -1, 2'd3, 16'h0100, 1'b0, 8'h3C, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[8]  = '{1'b0, 1'b1, -1, 1'b0, 1'b0, -1, 2'd0, 16'h0100, 1'b0, 8'h3C, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[9]  = '{1'b0, 1'b1,  2, 1'b0, 1'b0, -1, 2'd1, 16'h0100, 1'b1, 8'h3C, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[10] = '{1'b0, 1'b0,  0, 1'b0, 1'b0, -1, 2'd3, 16'h0100, 1'b0, 8'h3C, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[11] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, -1, 2'd0, 16'h0100, 1'b1, 8'h3C, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[12] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd1, 16'h0100, 1'b1, 8'h3C, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[13] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0100, 1'b1, 8'h10, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[14] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0101, 1'b1, 8'h11, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[15] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0102, 1'b1, 8'h12, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[16] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0103, 1'b1, 8'h13, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[17] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0104, 1'b1, 8'h14, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[18] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0105, 1'b1, 8'h15, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[19] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0106, 1'b1, 8'h16, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[20] = '{1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 2'd2, 16'h0107, 1'b1, 8'h17, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[21] = '{1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 2'd0, 16'h0108, 1'b1, 8'h17, 2'd1, 16'h0000, 1'b0, 8'h3C};
        vt[22] = '{1'b0, 1'b1, -1, 1'b0, 1'b0, -1, 2'd1, 16'h0108, 1'b1, 8'h17, 2'd0, 16'h0000, 1'b0, 8'h3C};
        vt[23] = '{1'b0, 1'b0, -1, 1'b0, 1'b0, -1, 2'd3, 16'h0100, 1'b0, 8'h17, 2'd1, 16'h0000, 1'b0, 8'h3C};

        for (int k = 0; k < 256; k++) ram_a[k] = 8'h00;
        ram_a[0] = 8'hA5;
        ram_a[1] = 8'h3C;

        reset = 1'b0; clk_enable = 1'b1;
        dmao_a = 1'b0; int_a = 1'b0; ie_set_a = 1'b0;
        dmao_b = 1'b0; int_b = 1'b0; ie_set_b = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        n_vec++;
        check("reset sc", 32'(sc_a), 32'd0);
        check("reset r0", 32'(r0_a), 32'h0100);
        check("reset ie", 32'(ie_a), 32'd1);
        check("reset data", 32'(data_a), 32'd0);
        check("reset tpb", 32'(tpb_a), 32'd0);
        check("reset rd_en", 32'(mem_rd_en_a), 32'd0);
        check("reset mem_addr", 32'(mem_addr_a), 32'd0);
        check("reset r0_b", 32'(r0_b), 32'hFFFF);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == 12)
                for (int k = 0; k < 8; k++) ram_a[k] = 8'(16 + k);
            run_vec(i);
        end

        // Stall mid-cycle (S0): freeze at tick 3 for 20 clk, then tpb must land three ticks later.
        n_vec++;
        repeat (3) @(negedge clk);
        clk_enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d sc", k), 32'(sc_a), 32'd0);
            check($sformatf("stall%0d tpb", k), 32'(tpb_a), 32'd0);
        end
        clk_enable = 1'b1;
        tpb_seen = -1;
        for (int k = 0; k < 5; k++) begin
            if (tpb_a) tpb_seen = k;
            @(negedge clk);
        end
        check("stall resume tpb offset", 32'(tpb_seen), 32'd3);
        check("stall resume sc", 32'(sc_a), 32'd1);

        // Reset at tick 3 of an S2 cycle whose R0 differs from FB_BASE.
        n_vec++;
        dmao_a = 1'b1;
        repeat (16) @(negedge clk);
        dmao_a = 1'b0;
        check("mid-reset pre sc", 32'(sc_a), 32'd2);
        check("mid-reset pre r0", 32'(r0_a), 32'h0101);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid-reset sc", 32'(sc_a), 32'd0);
        check("mid-reset r0", 32'(r0_a), 32'h0100);
        check("mid-reset ie", 32'(ie_a), 32'd1);
        check("mid-reset data", 32'(data_a), 32'd0);
        check("mid-reset rd_en", 32'(mem_rd_en_a), 32'd0);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post-reset r0", 32'(r0_a), 32'h0100);
        check("post-reset sc", 32'(sc_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pixie_dma_responder.md
Name: pixie_dma_responder

Overview:
- CPU-side counterpart of the Pixie display DMA/interrupt protocol: models the CDP1802 machine-cycle sequencer as seen by the Pixie front end.
- Answers the Pixie's `dmao` request with DMA-out cycles. Each cycle drives state code `sc`=2 and places the byte at R0 on `data`, then increments R0.
- Answers `int_pixie` with an interrupt cycle (`sc`=3) that reloads R0 with the frame-buffer base.
- Used for bring-up and verification of the display path without a full CPU core, and as the DMA/interrupt arbiter when one is attached.

Parameters:
- `FB_BASE`, 16'h0100, value loaded into R0 on interrupt acknowledge (display buffer start).
- `CYCLE_TICKS`, 8, `clk_enable` ticks per machine cycle (legal 6..16).
- `ADDR_W`, 16, memory address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `clk_enable`  in  1  tick qualifier; all state advances only when 1.
- `dmao`  in  1  DMA-out request from Pixie.
- `int_pixie`  in  1  interrupt request from Pixie.
- `ie_set`  in  1  one-`clk` pulse re-enabling interrupts (models RET).
- `mem_addr`  out  `ADDR_W`  memory read address.
- `mem_rd_en`  out  1  read strobe to synchronous RAM.
- `mem_data`  in  8  RAM read data, valid 1 `clk` after `mem_rd_en`.
- `sc`  out  2  state code: 0 fetch, 1 execute, 2 DMA, 3 interrupt.
- `data`  out  8  bus data during DMA cycles.
- `tpb`  out  1  timing pulse, one tick wide.
- `ie`  out  1  interrupt-enable flag.
- `r0`  out  `ADDR_W`  current DMA pointer.

Behaviour:
- **Reset** (`reset`=0 on a `clk` edge, regardless of `clk_enable`):
  - `sc`=0, tick counter=0, R0=`FB_BASE`, `ie`=1.
  - `data`=0, `mem_rd_en`=0, `tpb`=0, `mem_addr`=0.
  - Reset mid-cycle aborts the cycle immediately; no partial R0 increment.
- **Tick counter:** 0..`CYCLE_TICKS`-1, increments on `clk_enable`, wraps to 0 at cycle end.
- **`tpb`:** asserted for the single `clk` where `clk_enable`=1 and tick=`CYCLE_TICKS`-2.
- **Cycle decision:** made on the last tick (`CYCLE_TICKS`-1) of each cycle, sampling `dmao` and `int_pixie` at that tick. Priority:
  1. `dmao`=1 -> next cycle S2 (`sc`=2).
  2. else `int_pixie`=1 and `ie`=1 -> next cycle S3 (`sc`=3).
  3. else idle: alternate S0/S1. After S0 go to S1. After S1, S2 or S3 go to S0.
- **Repeated DMA:** consecutive S2 cycles are allowed while `dmao` is still 1 at each decision point. No S0/S1 is forced between them.
- **S2 (DMA out):**
  - Tick 0: `mem_rd_en`=1 for exactly one `clk` (gated by `clk_enable`), `mem_addr`=R0.
  - Next `clk`: `mem_data` is registered into `data`.
  - `data` is stable from tick 1 through the end of the cycle and holds its value outside S2.
  - Last tick: R0 <= R0+1, modulo 2^`ADDR_W` (0xFFFF -> 0x0000).
  - `dmao` deasserting mid-S2 does not shorten the cycle.
- **S3 (interrupt):**
  - On tick 0: `ie` <= 0 and R0 <= `FB_BASE`.
  - No memory access during S3.
- **Interrupt enable:**
  - `ie_set`=1 sets `ie` <= 1 on that `clk`, independent of `clk_enable`.
  - If `ie_set` coincides with the S3 tick-0 clear, the clear wins (`ie`=0).
  - `int_pixie` with `ie`=0 is ignored, not latched. It is taken at the first decision point where both are 1.
- **Output hold:** `sc` changes only on the `clk` where tick wraps to 0 and is held for the whole cycle.
- **`clk_enable`=0:** all state and outputs are frozen, except `ie_set` handling and the `mem_data` capture into `data`.

Test Plan:
1. **Reset:** reset low 3 clk, `clk_enable`=1 constant -> `sc`=0, R0=0x0100, `ie`=1, `data`=0. Idle `sc` sequence is 0,1,0,1, each held 8 ticks; `tpb` fires on tick 6.
2. **Single DMA:** RAM[0x0100]=0xA5, `dmao`=1 at one decision point -> one S2 cycle. One `mem_rd_en` at `mem_addr`=0x0100, `data`=0xA5 from tick 1, R0=0x0101 after the cycle, then S0.
3. **DMA burst:** `dmao` held for 8 decisions, RAM[0x0100..0x0107]=0x10..0x17 -> 8 back-to-back S2 cycles with `data` 0x10..0x17 in order, R0=0x0108.
4. **Simultaneous requests:** `dmao` and `int_pixie` asserted together -> S2 first. `int_pixie` still high at the next decision gives S3, `ie`=0, R0=0x0100. A further `int_pixie` is ignored until an `ie_set` pulse.
5. **Wrap and `ie` conflict:** force R0=0xFFFF via an interrupt with `FB_BASE`=16'hFFFF, then one DMA -> `mem_addr`=0xFFFF, R0=0x0000. `ie_set` on the same `clk` as S3 tick 0 -> `ie`=0.
6. **Reset and stall mid-cycle:**
   - Reset asserted at tick 3 of S2 -> next `clk` `sc`=0, R0=`FB_BASE`, no increment.
   - `clk_enable` held 0 for 20 clk mid-cycle -> tick, `sc` and `tpb` frozen; resumes at the same tick.
